// File: rtl/bram_ctrl_pkg.sv
// Shared types and helpers for the BRAM request-side controller.
//   rd_state_t : per-port read FSM states
//   byte_merge : byte-wise select between two words under a byte mask;
//                callers cast their own widths to/from MERGE_MAX_W.
package bram_ctrl_pkg;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_PEND = 2'd1,
        RD_HOLD = 2'd2
    } rd_state_t;

    localparam int unsigned MERGE_MAX_W = 1024;
    localparam int unsigned MERGE_MAX_B = MERGE_MAX_W / 8;

    // Byte b of the result is new_data[b] when mask[b] is set, else old_data[b].
    function automatic logic [MERGE_MAX_W-1:0] byte_merge(
        input logic [MERGE_MAX_W-1:0] old_data,
        input logic [MERGE_MAX_W-1:0] new_data,
        input logic [MERGE_MAX_B-1:0] mask
    );
        logic [MERGE_MAX_W-1:0] res;
        res = old_data;
        for (int unsigned b = 0; b < MERGE_MAX_B; b++) begin
            if (mask[b]) begin
                res[8*b +: 8] = new_data[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bram_rd_port_ctrl.sv
// One BRAM read port: valid/ready request handshake, 1-cycle read latency
// absorption, same-cycle write forwarding and a hold register for backpressure.
// Ports:
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   req_valid_i / req_ready_o     request handshake
//   resp_valid_o / resp_ready_i   response handshake, resp_data_o payload
//   wr_valid_i, wr_index_i,
//   wr_byte_en_i, wr_data_i       concurrent write, observed for forwarding
//   req_index_i                   index of the incoming request
//   ren_o                         BRAM read enable (== accept)
//   rdata_i                       BRAM read data, valid the cycle after ren_o
module bram_rd_port_ctrl
    import bram_ctrl_pkg::*;
#(
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned IDX_W  = 5,
    localparam int unsigned BYTES  = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [IDX_W-1:0]  req_index_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DATA_W-1:0] resp_data_o,
    input  logic              wr_valid_i,
    input  logic [BYTES-1:0]  wr_byte_en_i,
    input  logic [IDX_W-1:0]  wr_index_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              ren_o,
    input  logic [DATA_W-1:0] rdata_i
);

    rd_state_t         state_q;
    logic [BYTES-1:0]  fwd_mask_q;
    logic [DATA_W-1:0] fwd_data_q;
    logic [DATA_W-1:0] hold_q;

    logic              accept;
    logic [BYTES-1:0]  fwd_mask_c;
    logic [DATA_W-1:0] merged;

    // Handshake; everything is forced quiet while reset is asserted.
    assign req_ready_o  = rst_ni & ((state_q == RD_IDLE) | resp_ready_i);
    assign accept       = req_valid_i & req_ready_o;
    assign ren_o        = accept;
    assign resp_valid_o = rst_ni & (state_q != RD_IDLE);

    // Bytes written in the issue cycle are missing from the read-first BRAM data.
    assign fwd_mask_c = (wr_valid_i && (wr_index_i == req_index_i)) ? wr_byte_en_i : '0;
    assign merged     = DATA_W'(byte_merge(MERGE_MAX_W'(rdata_i),
                                           MERGE_MAX_W'(fwd_data_q),
                                           MERGE_MAX_B'(fwd_mask_q)));

    assign resp_data_o = (state_q == RD_PEND) ? merged : hold_q;

    // Read FSM with forward capture and hold register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= RD_IDLE;
            fwd_mask_q <= '0;
            fwd_data_q <= '0;
            hold_q     <= '0;
        end else begin
            if (accept) begin
                fwd_mask_q <= fwd_mask_c;
                fwd_data_q <= wr_data_i;
            end
            unique case (state_q)
                RD_IDLE: begin
                    if (accept) state_q <= RD_PEND;
                end
                RD_PEND: begin
                    if (resp_ready_i) begin
                        state_q <= accept ? RD_PEND : RD_IDLE;
                    end else begin
                        // BRAM output is only good for one cycle; freeze it here.
                        hold_q  <= merged;
                        state_q <= RD_HOLD;
                    end
                end
                RD_HOLD: begin
                    if (resp_ready_i) state_q <= accept ? RD_PEND : RD_IDLE;
                end
                default: state_q <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/bram_2r1w_req_ctrl.sv
// Request-side controller for a 2-read/1-write read-first BRAM.
// Two independent read clients (valid/ready) become BRAM read enables with
// 1-cycle latency; writes pass straight through and are forwarded into reads
// issued in the same cycle.
// Ports:
//   CLK, nRST                       clock, synchronous active-low reset
//   rd{0,1}_req_*                   read request handshake + index
//   rd{0,1}_resp_*                  read response handshake + data
//   wr_req_*                        write request (never stalled)
//   bram_port{0,1}_ren/rindex/rdata BRAM read ports
//   bram_wen_byte/windex/wdata      BRAM write port
// Optional: define BRAM_CTRL_STALL_CNT_EN to add rd{0,1}_stall_cnt, saturating
// counts of cycles with a response waiting on a not-ready consumer.
module bram_2r1w_req_ctrl
    import bram_ctrl_pkg::*;
#(
    parameter  int unsigned INNER_WIDTH = 32,
    parameter  int unsigned OUTER_WIDTH = 32,
    localparam int unsigned INDEX_WIDTH = $clog2(OUTER_WIDTH),
    localparam int unsigned BYTE_W      = INNER_WIDTH / 8
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   rd0_req_valid,
    output logic                   rd0_req_ready,
    input  logic [INDEX_WIDTH-1:0] rd0_req_index,
    output logic                   rd0_resp_valid,
    input  logic                   rd0_resp_ready,
    output logic [INNER_WIDTH-1:0] rd0_resp_data,
    input  logic                   rd1_req_valid,
    output logic                   rd1_req_ready,
    input  logic [INDEX_WIDTH-1:0] rd1_req_index,
    output logic                   rd1_resp_valid,
    input  logic                   rd1_resp_ready,
    output logic [INNER_WIDTH-1:0] rd1_resp_data,
    input  logic                   wr_req_valid,
    input  logic [BYTE_W-1:0]      wr_req_byte_en,
    input  logic [INDEX_WIDTH-1:0] wr_req_index,
    input  logic [INNER_WIDTH-1:0] wr_req_data,
    output logic                   bram_port0_ren,
    output logic [INDEX_WIDTH-1:0] bram_port0_rindex,
    input  logic [INNER_WIDTH-1:0] bram_port0_rdata,
    output logic                   bram_port1_ren,
    output logic [INDEX_WIDTH-1:0] bram_port1_rindex,
    input  logic [INNER_WIDTH-1:0] bram_port1_rdata,
    output logic [BYTE_W-1:0]      bram_wen_byte,
    output logic [INDEX_WIDTH-1:0] bram_windex,
    output logic [INNER_WIDTH-1:0] bram_wdata
`ifdef BRAM_CTRL_STALL_CNT_EN
    ,
    output logic [31:0]            rd0_stall_cnt,
    output logic [31:0]            rd1_stall_cnt
`endif
);

    // Write passthrough; byte enables are suppressed while in reset.
    assign bram_wen_byte = (nRST && wr_req_valid) ? wr_req_byte_en : '0;
    assign bram_windex   = wr_req_index;
    assign bram_wdata    = wr_req_data;

    assign bram_port0_rindex = rd0_req_index;
    assign bram_port1_rindex = rd1_req_index;

    bram_rd_port_ctrl #(.DATA_W(INNER_WIDTH), .IDX_W(INDEX_WIDTH)) u_rd0 (
        .clk_i        (CLK),
        .rst_ni       (nRST),
        .req_valid_i  (rd0_req_valid),
        .req_ready_o  (rd0_req_ready),
        .req_index_i  (rd0_req_index),
        .resp_valid_o (rd0_resp_valid),
        .resp_ready_i (rd0_resp_ready),
        .resp_data_o  (rd0_resp_data),
        .wr_valid_i   (wr_req_valid),
        .wr_byte_en_i (wr_req_byte_en),
        .wr_index_i   (wr_req_index),
        .wr_data_i    (wr_req_data),
        .ren_o        (bram_port0_ren),
        .rdata_i      (bram_port0_rdata)
    );

    bram_rd_port_ctrl #(.DATA_W(INNER_WIDTH), .IDX_W(INDEX_WIDTH)) u_rd1 (
        .clk_i        (CLK),
        .rst_ni       (nRST),
        .req_valid_i  (rd1_req_valid),
        .req_ready_o  (rd1_req_ready),
        .req_index_i  (rd1_req_index),
        .resp_valid_o (rd1_resp_valid),
        .resp_ready_i (rd1_resp_ready),
        .resp_data_o  (rd1_resp_data),
        .wr_valid_i   (wr_req_valid),
        .wr_byte_en_i (wr_req_byte_en),
        .wr_index_i   (wr_req_index),
        .wr_data_i    (wr_req_data),
        .ren_o        (bram_port1_ren),
        .rdata_i      (bram_port1_rdata)
    );

`ifdef BRAM_CTRL_STALL_CNT_EN
    // Saturating stall counters.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            rd0_stall_cnt <= '0;
            rd1_stall_cnt <= '0;
        end else begin
            if (rd0_resp_valid && !rd0_resp_ready && (rd0_stall_cnt != '1))
                rd0_stall_cnt <= rd0_stall_cnt + 32'd1;
            if (rd1_resp_valid && !rd1_resp_ready && (rd1_stall_cnt != '1))
                rd1_stall_cnt <= rd1_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/bram_2r1w_req_ctrl.md
Name: bram_2r1w_req_ctrl

Overview:
- Request-side controller that sits directly upstream of bram_2rport_1wport and drives its read and write ports.
- Converts two independent valid/ready read-request clients into BRAM read enables.
- Absorbs the BRAM's 1-cycle read latency and holds responses under consumer backpressure.
- Forwards same-cycle write bytes into read responses, because the BRAM is read-first.

Parameters:
- INNER_WIDTH, 32: data width in bits; must be a multiple of 8.
- OUTER_WIDTH, 32: number of BRAM entries; index width is $clog2(OUTER_WIDTH), held in local constant INDEX_WIDTH.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset; synchronous, active-low.
- rdN_req_valid  in  1  (N=0,1) read request valid.
- rdN_req_ready  out  1  read request accepted when valid & ready.
- rdN_req_index  in  INDEX_WIDTH  read index.
- rdN_resp_valid  out  1  response valid.
- rdN_resp_ready  in  1  consumer ready.
- rdN_resp_data  out  INNER_WIDTH  response data.
- wr_req_valid  in  1  write request.
- wr_req_byte_en  in  INNER_WIDTH/8  byte enables.
- wr_req_index  in  INDEX_WIDTH  write index.
- wr_req_data  in  INNER_WIDTH  write data.
- bram_portN_ren  out  1  to BRAM read enable.
- bram_portN_rindex  out  INDEX_WIDTH  to BRAM read index.
- bram_portN_rdata  in  INNER_WIDTH  from BRAM; valid the cycle after ren.
- bram_wen_byte  out  INNER_WIDTH/8  to BRAM.
- bram_windex  out  INDEX_WIDTH  to BRAM.
- bram_wdata  out  INNER_WIDTH  to BRAM.

Behaviour:
- Writes:
  - Never stalled; there is no wr_req_ready.
  - Combinational passthrough: bram_wen_byte = wr_req_valid ? wr_req_byte_en : 0; bram_windex/bram_wdata pass directly.
- Per-port read FSM, states RD_IDLE, RD_PEND, RD_HOLD:
  - rdN_req_ready = (state==RD_IDLE) | rdN_resp_ready.
  - Accept = rdN_req_valid & rdN_req_ready. bram_portN_ren = accept, bram_portN_rindex = rdN_req_index (combinational).
  - RD_IDLE: on accept -> RD_PEND.
  - RD_PEND:
    - rdN_resp_valid=1; rdN_resp_data = merge(bram_portN_rdata, fwd).
    - resp_ready=1: accept -> RD_PEND, else -> RD_IDLE.
    - resp_ready=0: capture the merged data into the hold register -> RD_HOLD.
  - RD_HOLD:
    - rdN_resp_valid=1; rdN_resp_data = hold register, stable.
    - resp_ready=1: accept -> RD_PEND, else -> RD_IDLE.
- Latency and throughput:
  - Request accepted in cycle N gives a response in cycle N+1.
  - One response per cycle per port while resp_ready stays high.
  - Responses are in order per port; the two ports are fully independent.
- Write forwarding:
  - At accept, record fwd_mask = (wr_req_valid & wr_req_index==rdN_req_index) ? wr_req_byte_en : 0, and fwd_data = wr_req_data.
  - merge: byte b comes from fwd_data if fwd_mask[b], otherwise from bram rdata.
  - Only writes in the same cycle as the read issue are forwarded. Earlier writes are already in the BRAM.
  - Writes landing after issue, including during RD_HOLD, do not alter the response. The response reflects memory as of the issue cycle plus same-cycle writes.
- Both ports may read the same index in the same cycle; each forwards independently.
- Reset (nRST=0 at a CLK edge):
  - State RD_IDLE; resp_valid 0; fwd_mask 0; hold register 0.
  - Combinational outputs (ren, wen) are forced 0 while nRST=0.
  - In-flight reads are dropped; no response follows reset.

Optional Feature:
- Macro BRAM_CTRL_STALL_CNT_EN.
- Defined:
  - Adds outputs rd0_stall_cnt and rd1_stall_cnt, 32 bits each.
  - Each counts cycles with rdN_resp_valid & ~rdN_resp_ready, saturating at 0xFFFFFFFF.
  - Reset to 0.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Package bram_ctrl_pkg:
  - rd_state_t enum {RD_IDLE, RD_PEND, RD_HOLD}.
  - Function byte_merge(old, new, mask), parameterised through the caller's widths.
- Sub-module bram_rd_port_ctrl:
  - One read FSM, forward capture and hold register; instantiated twice.
  - The top level holds the write passthrough and the optional counters.

Test Plan:
- Basic read: preload idx 5 = 0xDEADBEEF; rd0 req idx 5 in cycle 0 -> rd0_resp_valid in cycle 1 with 0xDEADBEEF; resp_ready=1 -> IDLE in cycle 2.
- Backpressure: rd0 resp_ready=0 for 3 cycles after issue -> resp_valid held, data stable, rd0_req_ready=0. Raise resp_ready -> exactly one response consumed. With BRAM_CTRL_STALL_CNT_EN, rd0_stall_cnt=3.
- Same-cycle write forwarding: idx 7 = 0x12345678; write idx 7, byte_en 4'b0011, data 0x0000ABCD, in the same cycle as rd1 req idx 7 -> response 0x1234ABCD.
- Write during HOLD: idx 9 = 0x11111111; read idx 9 with resp_ready=0; write idx 9 = 0xFFFFFFFF next cycle -> held response remains 0x11111111. A fresh read then returns 0xFFFFFFFF.
- Streaming: both ports issue 8 back-to-back reads (idx 0..7 and 7..0) with resp_ready=1 -> 8 consecutive responses per port, cycles 1..8, correct in-order data.
- Reset mid-operation: nRST=0 in the cycle after rd0 issue -> no rd0_resp_valid afterwards; all outputs 0 during reset; the first read after reset behaves as in the basic-read case.
